fm_layer_dispatch: RTL and testbench

- Initiator side of the feature-map guard-gen control handshake.
- Holds a small table of per-layer descriptors: w/h/c counts, kernel mode, bit mode.
- On start, issues the descriptors one by one to the guard-gen controller over ctrl_valid/ctrl_ready.
- Waits for each ctrl_finish pulse before issuing the next, and reports completion of the whole sequence to the top-level sequencer.

---
 rtl/fm_layer_dispatch.sv | 174 +++++++++++++++++
 tb/tb_fm_layer_dispatch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_layer_dispatch.sv
// fm_layer_dispatch: walks a small descriptor table and issues one layer at a time to the guard-gen controller.
// Define FM_DISPATCH_TIMEOUT_EN to add the WAIT-state watchdog and the sticky timeout_err output.
module fm_layer_dispatch #(
    parameter int DEPTH          = 8,
    parameter int AW             = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [7:0]    cfg_w,
    input  logic [7:0]    cfg_h,
    input  logic [7:0]    cfg_c,
    input  logic          cfg_kernal_mode,
    input  logic          cfg_bit_mode,
    input  logic          start,
    input  logic [AW:0]   layer_num,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_layer,
    output logic          ctrl_valid,
    input  logic          ctrl_ready,
    input  logic          ctrl_finish,
    output logic [7:0]    w_num_o,
    output logic [7:0]    h_num_o,
    output logic [7:0]    c_num_o,
    output logic          kernal_mode_o,
`ifdef FM_DISPATCH_TIMEOUT_EN
    output logic          bit_mode_o,
    output logic          timeout_err
`else
    output logic          bit_mode_o
`endif
);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("DEPTH must be a power of two equal to 2**AW");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit wait counter");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   n_q;
    logic [AW:0]   n_clamp;
    logic [25:0]   table_q [DEPTH];
    logic [AW-1:0] rd_addr;
    logic          load_desc;
    logic          advance;
    logic          last_layer;
    logic          start_ok;
    logic          timeout_hit;

    assign n_clamp    = (layer_num > DEPTH_L) ? DEPTH_L : layer_num;
    assign last_layer = ({1'b0, cur_layer} == (n_q - 1'b1));
    assign start_ok   = (state_q == IDLE) && start;

    assign ctrl_valid = (state_q == ISSUE);
    assign busy       = (state_q == ISSUE) || (state_q == WAIT);
    assign done       = (state_q == DONE);

`ifdef FM_DISPATCH_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // A finish in the final watchdog cycle still wins over the timeout.
    assign timeout_hit = (state_q == WAIT) && !ctrl_finish &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q == ISSUE && ctrl_ready)
                wait_cnt <= '0;
            else if (state_q == WAIT)
                wait_cnt <= wait_cnt + 1'b1;

            if (start_ok)
                timeout_err <= 1'b0;
            else if (timeout_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        load_desc = 1'b0;
        advance   = 1'b0;
        rd_addr   = cur_layer;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = ISSUE;
                        load_desc = 1'b1;
                        rd_addr   = '0;
                    end
                end
            end
            ISSUE: begin
                if (ctrl_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (ctrl_finish) begin
                    if (last_layer) begin
                        state_d = DONE;
                    end else begin
                        state_d   = ISSUE;
                        advance   = 1'b1;
                        load_desc = 1'b1;
                        rd_addr   = cur_layer + 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= '0;
            cur_layer <= '0;
        end else begin
            if (start_ok) begin
                n_q       <= n_clamp;
                cur_layer <= '0;
            end else if (advance) begin
                cur_layer <= cur_layer + 1'b1;
            end
        end
    end

    // Issued descriptor is registered so it is stable from the first ctrl_valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_num_o       <= '0;
            h_num_o       <= '0;
            c_num_o       <= '0;
            kernal_mode_o <= 1'b0;
            bit_mode_o    <= 1'b0;
        end else if (load_desc) begin
            {w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o} <= table_q[rd_addr];
        end
    end

    // Table has no reset; software loads it while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && cfg_we)
            table_q[cfg_addr] <= {cfg_w, cfg_h, cfg_c, cfg_kernal_mode, cfg_bit_mode};
    end

endmodule

// File: tb/tb_fm_layer_dispatch.sv
// Bench for fm_layer_dispatch: directed scenarios plus randomized runs against a descriptor-table model.
// Define FM_DISPATCH_TIMEOUT_EN to also exercise the watchdog with a 20-cycle limit.
`timescale 1ns/1ps
module tb_fm_layer_dispatch;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef FM_DISPATCH_TIMEOUT_EN
    localparam int TO    = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [7:0]    cfg_w = '0, cfg_h = '0, cfg_c = '0;
    logic          cfg_kernal_mode = 1'b0, cfg_bit_mode = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   layer_num = '0;
    logic          busy, done, ctrl_valid;
    logic [AW-1:0] cur_layer;
    logic          ctrl_ready = 1'b0, ctrl_finish = 1'b0;
    logic [7:0]    w_num_o, h_num_o, c_num_o;
    logic          kernal_mode_o, bit_mode_o;
`ifdef FM_DISPATCH_TIMEOUT_EN
    logic          timeout_err;
`endif

    logic [25:0] mdesc [DEPTH];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fm_layer_dispatch #(
        .DEPTH(DEPTH),
`ifdef FM_DISPATCH_TIMEOUT_EN
        .TIMEOUT_CYCLES(TO),
`endif
        .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_c(cfg_c),
        .cfg_kernal_mode(cfg_kernal_mode), .cfg_bit_mode(cfg_bit_mode),
        .start(start), .layer_num(layer_num),
        .busy(busy), .done(done), .cur_layer(cur_layer),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
        .w_num_o(w_num_o), .h_num_o(h_num_o), .c_num_o(c_num_o),
        .kernal_mode_o(kernal_mode_o),
`ifdef FM_DISPATCH_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .bit_mode_o(bit_mode_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [25:0] dout();
        return {w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o};
    endfunction

    task automatic wr(input int a, input logic [25:0] d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        {cfg_w, cfg_h, cfg_c, cfg_kernal_mode, cfg_bit_mode} = d;
        step();
        cfg_we   = 1'b0;
        mdesc[a] = d;
    endtask

    task automatic clear_inputs();
        ctrl_ready  = 1'b0;
        ctrl_finish = 1'b0;
        start       = 1'b0;
        cfg_we      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ctrl_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cur_layer", 32'(cur_layer), 32'd0);
        chk("rst_desc", 32'(dout()), 32'd0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // One start-to-done sequence. fin_dly: WAIT cycles before finish; bp: ready-low cycles per
    // layer (<0 random); poke: inject ignored start/cfg_we/finish; abort_at: layer to reset in.
    task automatic run_seq(input int lnum, input int fin_dly, input int bp, input bit poke,
                           input int abort_at);
        int n, k, wcnt, bp_left, cyc;
        bit waiting;
        n = (lnum > DEPTH) ? DEPTH : lnum;
        k = 0; wcnt = 0; cyc = 0; waiting = 1'b0;
        bp_left = (bp < 0) ? int'($urandom_range(3, 0)) : bp;
        start = 1'b1;
        layer_num = (AW+1)'(lnum);
        step();
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_valid", 32'(ctrl_valid), 32'd0);
            chk("zero_busy", 32'(busy), 32'd0);
            step();
            chk("zero_done_end", 32'(done), 32'd0);
            chk("zero_valid_end", 32'(ctrl_valid), 32'd0);
            return;
        end
        while (k < n) begin
            cyc++;
            if (cyc > 2000) begin
                chk("cycle_budget", 32'd0, 32'd1);
                clear_inputs();
                return;
            end
            clear_inputs();
            chk("busy", 32'(busy), 32'd1);
            chk("done_mid", 32'(done), 32'd0);
            chk("cur_layer", 32'(cur_layer), 32'(k));
            chk("desc", 32'(dout()), 32'(mdesc[k]));
            if (!waiting) begin
                chk("valid_issue", 32'(ctrl_valid), 32'd1);
                if (poke) ctrl_finish = 1'b1;
                if (bp_left > 0) begin
                    bp_left--;
                end else begin
                    ctrl_ready = 1'b1;
                    waiting = 1'b1;
                    wcnt = 0;
                end
            end else begin
                chk("valid_wait", 32'(ctrl_valid), 32'd0);
                wcnt++;
                if (k == abort_at && wcnt == 3) begin
                    do_reset();
                    return;
                end
                if (poke && wcnt == 1) begin
                    start = 1'b1;
                    cfg_we = 1'b1;
                    cfg_addr = AW'(1);
                    {cfg_w, cfg_h, cfg_c, cfg_kernal_mode, cfg_bit_mode} = ~mdesc[1];
                end
                if (wcnt == fin_dly) begin
                    ctrl_finish = 1'b1;
                    k++;
                    waiting = 1'b0;
                    bp_left = (bp < 0) ? int'($urandom_range(3, 0)) : bp;
                end
            end
            step();
        end
        clear_inputs();
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(ctrl_valid), 32'd0);
        chk("end_cur_layer", 32'(cur_layer), 32'(n - 1));
        step();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cur_layer", 32'(cur_layer), 32'(n - 1));
    endtask

`ifdef FM_DISPATCH_TIMEOUT_EN
    task automatic run_timeout();
        start = 1'b1;
        layer_num = (AW+1)'(2);
        step();
        start = 1'b0;
        chk("to_valid", 32'(ctrl_valid), 32'd1);
        ctrl_ready = 1'b1;
        step();
        ctrl_ready = 1'b0;
        for (int i = 1; i <= TO + 1; i++) begin
            if (i <= TO) begin
                chk("to_done_early", 32'(done), 32'd0);
                chk("to_err_early", 32'(timeout_err), 32'd0);
                chk("to_valid_wait", 32'(ctrl_valid), 32'd0);
            end else begin
                chk("to_done", 32'(done), 32'd1);
                chk("to_err", 32'(timeout_err), 32'd1);
                chk("to_busy", 32'(busy), 32'd0);
            end
            step();
        end
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        chk("to_idle_valid", 32'(ctrl_valid), 32'd0);
        start = 1'b1;
        layer_num = '0;
        step();
        start = 1'b0;
        chk("to_err_cleared", 32'(timeout_err), 32'd0);
        step();
    endtask
`endif

    initial begin
        #2;
        chk("reset_valid", 32'(ctrl_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_cur_layer", 32'(cur_layer), 32'd0);
        chk("reset_desc", 32'(dout()), 32'd0);
`ifdef FM_DISPATCH_TIMEOUT_EN
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        wr(0, {8'd4, 8'd4, 8'd2, 1'b0, 1'b0});
        wr(1, {8'd8, 8'd2, 8'd3, 1'b1, 1'b1});
        wr(2, {8'd1, 8'd1, 8'd1, 1'b0, 1'b0});
        run_seq(3, 10, 0, 1'b0, -1);
        run_seq(2, 4, 5, 1'b0, -1);
        run_seq(0, 1, 0, 1'b0, -1);
        run_seq(3, 6, 2, 1'b1, -1);
        run_seq(3, 3, 0, 1'b0, -1);

        for (int i = 0; i < DEPTH; i++) wr(i, 26'($urandom));
        run_seq(DEPTH, 3, 0, 1'b0, 4);
        run_seq(DEPTH + 4, 2, 1, 1'b0, -1);

`ifdef FM_DISPATCH_TIMEOUT_EN
        run_timeout();
`endif

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(1, 0) == 1) wr(int'($urandom_range(DEPTH - 1, 0)), 26'($urandom));
            run_seq(int'($urandom_range(12, 0)), int'($urandom_range(6, 1)), -1,
                    1'($urandom_range(1, 0)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
